// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential saturating multiplier.
//   state_t        - controller state encoding (IDLE, CALC, DONE)
//   DEF_WIDTH      - default operand width
//   DEF_OUT_WIDTH  - default result width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_OUT_WIDTH = 7;

endpackage

// File: rtl/mult_saturate.sv
// mult_saturate: combinational narrowing of the exact product.
//   i_full     [2*WIDTH]   exact unsigned product
//   i_sat_en   [1]         1 = clamp to all ones on overflow, 0 = truncate
//   o_product  [OUT_WIDTH] saturated or truncated result
//   o_overflow [1]         product does not fit in OUT_WIDTH bits
module mult_saturate #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 7
) (
  input  logic [2*WIDTH-1:0]   i_full,
  input  logic                 i_sat_en,
  output logic [OUT_WIDTH-1:0] o_product,
  output logic                 o_overflow
);

  logic w_ov;

  generate
    if (OUT_WIDTH >= 2*WIDTH) begin : g_nosat
      // Result holds every product bit; overflow is impossible.
      assign w_ov = 1'b0;
    end else begin : g_sat
      assign w_ov = |i_full[2*WIDTH-1:OUT_WIDTH];
    end
  endgenerate

  assign o_overflow = w_ov;
  assign o_product  = (w_ov && i_sat_en) ? '1 : i_full[OUT_WIDTH-1:0];

endmodule

// File: rtl/sat_seq_multiplier.sv
// sat_seq_multiplier: shift-and-add unsigned multiplier, one partial
// product per clock, with optional saturation of the narrowed result.
//   clk, rst_n     clock, async active-low reset
//   start          one-cycle request; a, b, sat_en sampled with it
//   busy           high in CALC and DONE
//   done           one-cycle pulse when product/overflow/full_product update
//   product        OUT_WIDTH result (saturated or truncated)
//   overflow       full product exceeds OUT_WIDTH bits
//   full_product   exact 2*WIDTH product
// Latency: WIDTH+1 clocks from the start-sampling edge to the done cycle.
module sat_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sat_en,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] product,
  output logic                 overflow,
  output logic [2*WIDTH-1:0]   full_product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 r_state, w_next;
  logic [2*WIDTH-1:0]     r_mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]       r_mplier;  // multiplier, shifted right each step
  logic [2*WIDTH-1:0]     r_acc;
  logic [CW-1:0]          r_cnt;
  logic                   r_sat;
  logic                   r_rdy;     // low for the first edge after reset release
  logic                   r_done;
  logic [OUT_WIDTH-1:0]   r_product;
  logic                   r_overflow;
  logic [2*WIDTH-1:0]     r_full;

  logic                   w_accept;
  logic [2*WIDTH-1:0]     w_sum;
  logic [OUT_WIDTH-1:0]   w_product;
  logic                   w_overflow;

  // The done-pulse cycle is already IDLE, so start is also masked there.
  assign w_accept = (r_state == IDLE) && start && r_rdy && !r_done;

  // Single shared adder; the partial product is gated by the multiplier LSB.
  assign w_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (r_cnt == CW'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
      r_sat    <= sat_en;
    end else if (r_state == CALC) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  mult_saturate #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .i_full     (r_acc),
    .i_sat_en   (r_sat),
    .o_product  (w_product),
    .o_overflow (w_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
      r_full     <= '0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_product  <= w_product;
        r_overflow <= w_overflow;
        r_full     <= r_acc;
      end
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign product      = r_product;
  assign overflow     = r_overflow;
  assign full_product = r_full;

endmodule

// File: tb/tb_sat_seq_multiplier.sv
module tb_sat_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        sat_en = 1'b0;

  logic        busy_n, done_n, ov_n;
  logic [6:0]  prod_n;
  logic [15:0] full_n;
  logic        busy_w, done_w, ov_w;
  logic [15:0] prod_w;
  logic [15:0] full_w;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sat_seq_multiplier #(.WIDTH(8), .OUT_WIDTH(7)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sat_en(sat_en),
    .busy(busy_n), .done(done_n), .product(prod_n), .overflow(ov_n),
    .full_product(full_n)
  );

  sat_seq_multiplier #(.WIDTH(8), .OUT_WIDTH(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sat_en(sat_en),
    .busy(busy_w), .done(done_w), .product(prod_w), .overflow(ov_w),
    .full_product(full_w)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    int         prod;
    int         ov;
    int         full;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for done; n = edges after the start-sampling edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done_n && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input logic is, output int n);
    @(negedge clk);
    a = ia; b = ib; sat_en = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
  endtask

  initial begin
    int n;
    int cnt;

    vt[0] = '{8'd12,  8'd10,  1'b1, 120, 0, 120};
    vt[1] = '{8'd15,  8'd10,  1'b1, 127, 1, 150};
    vt[2] = '{8'd15,  8'd10,  1'b0, 22,  1, 150};
    vt[3] = '{8'd0,   8'd0,   1'b1, 0,   0, 0};
    vt[4] = '{8'd255, 8'd255, 1'b1, 127, 1, 65025};
    vt[5] = '{8'd255, 8'd255, 1'b0, 1,   1, 65025};
    vt[6] = '{8'd11,  8'd11,  1'b1, 121, 0, 121};
    vt[7] = '{8'd127, 8'd1,   1'b0, 127, 0, 127};
    vt[8] = '{8'd64,  8'd2,   1'b0, 0,   1, 128};

    // Reset state
    #12;
    chk("rst_busy", busy_n, 0);
    chk("rst_done", done_n, 0);
    chk("rst_prod", prod_n, 0);
    chk("rst_full", full_n, 0);
    chk("rst_wide_prod", prod_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    foreach (vt[i]) begin
      do_op(vt[i].a, vt[i].b, vt[i].s, n);
      chk($sformatf("v%0d_latency", i), n, 9);
      chk($sformatf("v%0d_prod", i), prod_n, vt[i].prod);
      chk($sformatf("v%0d_ov", i), ov_n, vt[i].ov);
      chk($sformatf("v%0d_full", i), full_n, vt[i].full);
      chk($sformatf("v%0d_wide_done", i), done_w, 1);
      chk($sformatf("v%0d_wide_prod", i), prod_w, vt[i].full);
      chk($sformatf("v%0d_wide_ov", i), ov_w, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done_n, 0);
      chk($sformatf("v%0d_hold", i), full_n, vt[i].full);
    end

    // Start during the done cycle is ignored; the next cycle is accepted
    do_op(8'd5, 8'd5, 1'b1, n);
    chk("dc_latency", n, 9);
    chk("dc_prod", prod_n, 25);
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk);
    chk("dc_ignored", busy_n, 0);
    @(negedge clk);
    start = 1'b0;
    chk("dc_next_accepted", busy_n, 1);
    wait_done(n);
    chk("dc_next_latency", n, 9);
    chk("dc_next_prod", prod_n, 49);
    @(negedge clk);

    // Start while busy is ignored, no queued second result
    @(negedge clk);
    a = 8'd3; b = 8'd4; sat_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid", busy_n, 1);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (done_n) begin
        cnt++;
        chk("busy_prod", prod_n, 12);
      end
      @(negedge clk);
    end
    chk("busy_done_count", cnt, 1);
    chk("busy_full_hold", full_n, 12);

    // Reset mid-CALC aborts; start in the release cycle is ignored
    a = 8'd200; b = 8'd2; sat_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_n, 0);
    chk("abort_prod", prod_n, 0);
    chk("abort_full", full_n, 0);
    chk("abort_ov", ov_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("release_start_ignored", busy_n, 0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_n) cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", cnt, 0);
    do_op(8'd2, 8'd3, 1'b1, n);
    chk("post_rst_latency", n, 9);
    chk("post_rst_prod", prod_n, 6);
    chk("post_rst_ov", ov_n, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
